sbox_share_arbiter: RTL

- Shares one combinational composite-field S-box / GF(2^8) inversion datapath among NUM_REQ requesters, e.g. round byte lanes and key expansion.
- Requesters use a per-port valid/ready handshake. One byte is granted per cycle by round-robin arbitration.
- The granted byte is registered into the shared datapath. Its result is registered back and returned to the owning requester 2 cycles after grant.
- Supports a burst lock so key expansion can take 4 consecutive slots for RotWord/SubWord.

---
 rtl/sbox_share_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sbox_share_arbiter.sv
// rtl/sbox_share_arbiter.sv - round-robin arbiter with burst lock sharing one S-box datapath
module sbox_share_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int SBOX_INPUT_WIDTH = 8,
    parameter int TAG_W            = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0]                   req_lock,
    input  logic [NUM_REQ*SBOX_INPUT_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [SBOX_INPUT_WIDTH-1:0]          sbox_in,
    input  logic [SBOX_INPUT_WIDTH-1:0]          sbox_out,
    output logic [NUM_REQ-1:0]                   rsp_valid,
    output logic [SBOX_INPUT_WIDTH-1:0]          rsp_data,
    output logic                                 busy
);

    typedef enum logic {ST_ARB, ST_LOCKED} state_t;

    state_t                      state_q, state_d;
    logic [TAG_W-1:0]            ptr_q, ptr_d;
    logic [TAG_W-1:0]            owner_q, owner_d;
    logic [TAG_W-1:0]            gnt_idx;
    logic [TAG_W-1:0]            cand;
    logic                        gnt_any;
    logic [SBOX_INPUT_WIDTH-1:0] gnt_byte;
    int                          scan;

    logic                        s1_valid;
    logic [TAG_W-1:0]            s1_tag;
    logic [NUM_REQ-1:0]          s1_onehot;

    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        cand     = '0;
        scan     = 0;
        gnt_byte = '0;
        req_ready = '0;
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;

        // Scan downward so the candidate closest to the pointer is the last one kept.
        if (state_q == ST_ARB) begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                scan = int'(ptr_q) + k;
                if (scan >= NUM_REQ) scan = scan - NUM_REQ;
                cand = TAG_W'(scan);
                if (req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end else if (req_valid[owner_q]) begin
            gnt_any = 1'b1;
            gnt_idx = owner_q;
        end

        if (rst || flush) gnt_any = 1'b0;
        if (gnt_any) req_ready[gnt_idx] = 1'b1;

        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == TAG_W'(i)) gnt_byte = req_data[i*SBOX_INPUT_WIDTH +: SBOX_INPUT_WIDTH];
        end

        case (state_q)
            ST_ARB: begin
                if (gnt_any) begin
                    ptr_d = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    if (req_lock[gnt_idx]) begin
                        state_d = ST_LOCKED;
                        owner_d = gnt_idx;
                    end
                end
            end
            ST_LOCKED: begin
                // Owner may idle with the lock held; dropping lock releases it whether or not it hands over a last beat.
                if (!req_lock[owner_q] && (gnt_any || !req_valid[owner_q])) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase

        if (flush) state_d = ST_ARB;
    end

    assign s1_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << s1_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ARB;
            ptr_q     <= '0;
            owner_q   <= '0;
            s1_valid  <= 1'b0;
            s1_tag    <= '0;
            sbox_in   <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            s1_valid <= gnt_any;
            if (gnt_any) begin
                sbox_in <= gnt_byte;
                s1_tag  <= gnt_idx;
            end
            if (s1_valid && !flush) begin
                rsp_valid <= s1_onehot;
                rsp_data  <= sbox_out;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

    assign busy = s1_valid | (|rsp_valid) | (state_q == ST_LOCKED);

endmodule
